// File: rtl/fifo_bus_sched_pkg.sv
// Shared encodings and sizing helpers for the half-duplex FIFO bus scheduler.
package fifo_bus_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  typedef enum logic {
    DIR_WRITE = 1'b0,
    DIR_READ  = 1'b1
  } dir_t;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int get_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic dir_t flip_dir(input dir_t d);
    return (d == DIR_WRITE) ? DIR_READ : DIR_WRITE;
  endfunction

  function automatic state_t dir_state(input dir_t d);
    return (d == DIR_WRITE) ? ST_WRITE : ST_READ;
  endfunction

endpackage

// File: rtl/fifo_bus_sched.sv
// Grants a shared half-duplex FIFO data bus to a producer or consumer in bounded
// bursts, inserting a turnaround gap on every direction change.
module fifo_bus_sched
  import fifo_bus_sched_pkg::*;
#(
  parameter int BURST_LEN   = 4,
  parameter int TURN_CYCLES = 1,
  parameter int CNT_WIDTH   = get_width(max_int(BURST_LEN, TURN_CYCLES))
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_req,
  input  logic                 rd_req,
  input  logic                 full,
  input  logic                 empty,
  output logic                 en_write,
  output logic                 en_read,
  output logic                 wr_gnt,
  output logic                 rd_gnt,
  output logic                 turn,
  output logic [CNT_WIDTH-1:0] beat_cnt
);

  localparam logic [CNT_WIDTH-1:0] BURST_LAST = CNT_WIDTH'(BURST_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] TURN_LAST  = CNT_WIDTH'(TURN_CYCLES - 1);

  state_t               state;
  dir_t                 target;
  dir_t                 last_dir;
  dir_t                 pick;
  dir_t                 cur_dir;
  logic                 dir_valid;
  logic [CNT_WIDTH-1:0] cnt;

  logic wr_ok, rd_ok, own_ok, other_ok, burst_end;

  assign wr_ok = wr_req & ~full;
  assign rd_ok = rd_req & ~empty;

  // Strobes gate on the flags in the same cycle, so the FIFO can never over/underflow.
  assign en_write = (state == ST_WRITE) & wr_ok;
  assign en_read  = (state == ST_READ)  & rd_ok;
  assign wr_gnt   = (state == ST_WRITE);
  assign rd_gnt   = (state == ST_READ);
  assign turn     = (state == ST_TURN);
  assign beat_cnt = cnt;

  // WRITE and READ share one burst engine; these views are only meaningful there.
  assign cur_dir   = (state == ST_READ) ? DIR_READ : DIR_WRITE;
  assign own_ok    = (state == ST_READ) ? rd_ok : wr_ok;
  assign other_ok  = (state == ST_READ) ? wr_ok : rd_ok;
  assign burst_end = ~own_ok | (cnt == BURST_LAST);

  always_comb begin
    pick = DIR_WRITE;
    if (wr_ok && rd_ok)
      pick = dir_valid ? flip_dir(last_dir) : DIR_WRITE;
    else if (rd_ok)
      pick = DIR_READ;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      target    <= DIR_WRITE;
      last_dir  <= DIR_WRITE;
      dir_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_ok || rd_ok) begin
            cnt <= '0;
            if (!dir_valid || pick == last_dir) begin
              state <= dir_state(pick);
            end else begin
              state  <= ST_TURN;
              target <= pick;
            end
          end
        end

        ST_WRITE, ST_READ: begin
          if (burst_end) begin
            // last_dir is only trustworthy once a burst has ended, so validate it here
            // too; otherwise a later idle->opposite grant would skip the turnaround.
            cnt       <= '0;
            last_dir  <= cur_dir;
            dir_valid <= 1'b1;
            if (other_ok) begin
              state  <= ST_TURN;
              target <= flip_dir(cur_dir);
            end else if (!own_ok) begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_TURN: begin
          if (cnt == TURN_LAST) begin
            state     <= dir_state(target);
            cnt       <= '0;
            dir_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_bus_sched.sv
// Directed + randomized bench for fifo_bus_sched against a bus-ownership model.
module tb_fifo_bus_sched;

  localparam int BURST = 4;
  localparam int TURN  = 1;
  localparam int TURN3 = 3;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_req = 1'b0, rd_req = 1'b0, full = 1'b0, empty = 1'b1;
  logic       en_write, en_read, wr_gnt, rd_gnt, turn;
  logic [1:0] beat_cnt;

  logic       wr_req3 = 1'b0, rd_req3 = 1'b0, full3 = 1'b0, empty3 = 1'b1;
  logic       ew3, er3, wg3, rg3, tn3;
  logic [1:0] bc3;

  int errors = 0;
  int checks = 0;
  int level  = 0;

  // Model: mode 0 idle, 1 write owns bus, 2 read owns bus, 3 turnaround
  int m_mode, m_beats, m_turn_left, m_target, m_last;
  bit m_valid;

  bit s_ew, s_er, s_tn, s_rg;

  always #5 clk = ~clk;

  fifo_bus_sched #(.BURST_LEN(BURST), .TURN_CYCLES(TURN)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .full(full), .empty(empty),
    .en_write(en_write), .en_read(en_read), .wr_gnt(wr_gnt), .rd_gnt(rd_gnt),
    .turn(turn), .beat_cnt(beat_cnt)
  );

  fifo_bus_sched #(.BURST_LEN(BURST), .TURN_CYCLES(TURN3)) dut3 (
    .clk(clk), .rst(rst), .wr_req(wr_req3), .rd_req(rd_req3), .full(full3), .empty(empty3),
    .en_write(ew3), .en_read(er3), .wr_gnt(wg3), .rd_gnt(rg3),
    .turn(tn3), .beat_cnt(bc3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_beats = 0; m_turn_left = 0; m_target = 1; m_last = 1; m_valid = 0;
  endtask

  task automatic model_adv();
    bit wok, rok, own, oth;
    int want;
    wok = wr_req && !full;
    rok = rd_req && !empty;
    case (m_mode)
      0: if (wok || rok) begin
        if (wok && rok) want = m_valid ? 3 - m_last : 1;
        else            want = wok ? 1 : 2;
        if (!m_valid || want == m_last) m_mode = want;
        else begin m_target = want; m_mode = 3; m_turn_left = TURN; end
      end
      1, 2: begin
        own = (m_mode == 1) ? wok : rok;
        oth = (m_mode == 1) ? rok : wok;
        if (own) m_beats++;
        if (!own || m_beats == BURST) begin
          m_beats = 0; m_last = m_mode; m_valid = 1;
          if (oth) begin m_target = 3 - m_mode; m_mode = 3; m_turn_left = TURN; end
          else if (!own) m_mode = 0;
        end
      end
      default: begin
        m_turn_left--;
        if (m_turn_left == 0) begin m_mode = m_target; m_beats = 0; m_valid = 1; end
      end
    endcase
  endtask

  task automatic check_outs();
    bit wok, rok;
    int e_cnt;
    wok   = wr_req && !full;
    rok   = rd_req && !empty;
    e_cnt = (m_mode == 3) ? TURN - m_turn_left : m_beats;
    chk("en_write", 32'(en_write), 32'(m_mode == 1 && wok));
    chk("en_read",  32'(en_read),  32'(m_mode == 2 && rok));
    chk("wr_gnt",   32'(wr_gnt),   32'(m_mode == 1));
    chk("rd_gnt",   32'(rd_gnt),   32'(m_mode == 2));
    chk("turn",     32'(turn),     32'(m_mode == 3));
    chk("beat_cnt", 32'(beat_cnt), 32'(e_cnt));
    chk("both_strobes",     32'(en_write & en_read), 32'(0));
    chk("read_while_empty", 32'(en_read & empty),    32'(0));
    chk("write_while_full", 32'(en_write & full),    32'(0));
  endtask

  // One clock cycle: drive flags from the FIFO level, check, clock, update model/level.
  task automatic cyc();
    bit ew, er;
    full  = (level >= DEPTH);
    empty = (level <= 0);
    #1;
    check_outs();
    s_ew = en_write; s_er = en_read; s_tn = turn; s_rg = rd_gnt;
    ew = (m_mode == 1) && wr_req && !full;
    er = (m_mode == 2) && rd_req && !empty;
    @(posedge clk);
    model_adv();
    level += int'(ew) - int'(er);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_outs"}, 32'({en_write, en_read, wr_gnt, rd_gnt, turn}), 32'(0));
    chk({tag, "_cnt"},  32'(beat_cnt), 32'(0));
    chk({tag, "_outs3"}, 32'({ew3, er3, wg3, rg3, tn3, bc3}), 32'(0));
  endtask

  // Entered at or after a negedge; leaves at a negedge with rst released.
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    chk_zero("rst_async");
    repeat (2) @(negedge clk);
    #1;
    chk_zero("rst_hold");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int cnt, tc, bad, first, run, maxrun, turns;
    model_reset();
    @(negedge clk);
    do_reset();

    // Write-only into an empty FIFO: immediate grant, back-to-back bursts until full
    level = 0; wr_req = 1'b1; rd_req = 1'b0;
    repeat (11) cyc();

    // Both sides, FIFO with 2 entries
    do_reset();
    level = 2; wr_req = 1'b1; rd_req = 1'b1;
    repeat (20) cyc();

    // Only 2 free slots: exactly two write beats
    do_reset();
    level = 6; wr_req = 1'b1; rd_req = 1'b0; cnt = 0;
    repeat (8) begin cyc(); cnt += int'(s_ew); end
    chk("writes_into_2_free", 32'(cnt), 32'(2));

    // Both requesting for 40 cycles, mid-level: single-cycle turnarounds
    do_reset();
    level = 4; wr_req = 1'b1; rd_req = 1'b1; run = 0; maxrun = 0; turns = 0;
    repeat (40) begin
      cyc();
      if (s_tn) begin run++; turns++; end else run = 0;
      if (run > maxrun) maxrun = run;
    end
    chk("turn_run_len", 32'(maxrun), 32'(TURN));
    chk("turns_seen_nonzero", 32'(turns > 4), 32'(1));

    // TURN_CYCLES=3 instance: direction switch
    wr_req = 1'b0; rd_req = 1'b0;
    do_reset();
    wr_req3 = 1'b1; rd_req3 = 1'b0; empty3 = 1'b1; full3 = 1'b0;
    repeat (3) cyc();
    wr_req3 = 1'b0; rd_req3 = 1'b1; empty3 = 1'b0;
    tc = 0; bad = 0; first = -1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (tn3) tc++;
      if (tn3 && (ew3 || er3)) bad++;
      if (rg3 && er3 && first < 0) first = i;
      cyc();
    end
    chk("turn3_cycles", 32'(tc), 32'(TURN3));
    chk("turn3_strobes", 32'(bad), 32'(0));
    chk("turn3_first_read", 32'(first), 32'(4));
    rd_req3 = 1'b0; empty3 = 1'b1;

    // Reset during beat 2 of a write burst, then a read grant with no turnaround
    do_reset();
    level = 0; wr_req = 1'b1; rd_req = 1'b0;
    repeat (3) cyc();
    full = 1'b0; empty = 1'b1;
    #1;
    chk("beat2_en_write", 32'(en_write), 32'(1));
    do_reset();
    wr_req = 1'b0; rd_req = 1'b1; level = 3;
    cyc();
    cyc();
    chk("rd_gnt_after_rst", 32'(s_rg), 32'(1));
    chk("no_turn_after_rst", 32'(s_tn), 32'(0));
    repeat (4) cyc();

    // Random traffic with occasional external level jumps
    do_reset();
    level = int'($urandom_range(0, DEPTH));
    repeat (400) begin
      wr_req = ($urandom_range(0, 3) != 0);
      rd_req = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) level = int'($urandom_range(0, DEPTH));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
